// File: rtl/conv_pool_layer_ctrl_if.sv
// rtl/conv_pool_layer_ctrl_if.sv - memory, window and result buses of the conv/pool layer controller
interface conv_pool_layer_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int IN_CH      = 6,
    parameter int FILT_PAR   = 2,
    parameter int ADDR_W     = 12
);
    logic [ADDR_W-1:0]                    feat_addr;
    logic                                 feat_valid;
    logic [ADDR_W-1:0]                    wt_addr;
    logic                                 wt_valid;
    logic                                 win_valid;
    logic                                 win_ready;
    logic [ADDR_W-1:0]                    win_row;
    logic [ADDR_W-1:0]                    win_col;
    logic                                 mac_valid;
    logic [FILT_PAR*IN_CH*DATA_WIDTH-1:0] mac_data;
    logic                                 out_we;
    logic [ADDR_W-1:0]                    out_addr;
    logic [FILT_PAR*DATA_WIDTH-1:0]       out_data;

    modport master (
        output feat_addr, feat_valid, wt_addr, wt_valid,
        output win_valid, win_row, win_col,
        output out_we, out_addr, out_data,
        input  win_ready, mac_valid, mac_data
    );

    modport slave (
        input  feat_addr, feat_valid, wt_addr, wt_valid,
        input  win_valid, win_row, win_col,
        input  out_we, out_addr, out_data,
        output win_ready, mac_valid, mac_data
    );
endinterface

// File: rtl/conv_pool_layer_ctrl.sv
// rtl/conv_pool_layer_ctrl.sv - conv + optional ReLU / 2x2 max-pool layer sequencer for a LeNet-5 MAC array
module conv_pool_layer_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int IN_W       = 14,
    parameter int IN_H       = 14,
    parameter int IN_CH      = 6,
    parameter int K          = 5,
    parameter int NUM_FILT   = 16,
    parameter int FILT_PAR   = 2,
    parameter int ADDR_W     = 12,
    parameter int MEM_LAT    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic relu_en,
    input  logic pool_en,
    output logic busy,
    output logic done,
    conv_pool_layer_ctrl_if.master bus
);
    localparam int OUT_W  = IN_W - K + 1;
    localparam int OUT_H  = IN_H - K + 1;
    localparam int N_IN   = IN_W * IN_H;
    localparam int N_RES  = OUT_W * OUT_H;
    localparam int WPF    = K * K * IN_CH + 1;
    localparam int PASSES = NUM_FILT / FILT_PAR;
    localparam int SW     = DATA_WIDTH + $clog2(IN_CH + 1);
    localparam int PB_N   = (OUT_W / 2 > 0) ? OUT_W / 2 : 1;
    localparam int PB_IW  = (PB_N > 1) ? $clog2(PB_N) : 1;
    localparam bit W_ODD  = (OUT_W % 2) == 1;
    localparam bit H_ODD  = (OUT_H % 2) == 1;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_INP, S_LOAD_WT, S_CONV, S_DRAIN, S_DONE
    } state_t;

    state_t              state;
    logic                relu_q, pool_q;
    logic [ADDR_W-1:0]   pass;
    logic [ADDR_W-1:0]   wt_base;
    logic                feat_iss, wt_iss;
    logic [MEM_LAT-1:0]  feat_sr, wt_sr;
    logic [MEM_LAT-1:0]  feat_sr_nxt, wt_sr_nxt;
    logic [ADDR_W-1:0]   wt_cnt;

    logic [ADDR_W-1:0]   res_cnt, res_r, res_c;
    logic                res_take;
    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_r, s1_c;
    logic signed [DATA_WIDTH-1:0] s1_val [FILT_PAR];
    logic signed [DATA_WIDTH-1:0] lane_res [FILT_PAR];
    logic signed [DATA_WIDTH-1:0] ptmp [FILT_PAR];
    logic signed [DATA_WIDTH-1:0] pbuf [FILT_PAR][PB_N];
    logic signed [SW-1:0] acc;
    logic [ADDR_W-1:0]   wr_cnt;
    logic [PB_IW-1:0]    pidx;
    logic                pool_drop;

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // The valid strobes are the issue strobes pushed through a MEM_LAT-deep shift register.
    assign feat_sr_nxt    = MEM_LAT'({feat_sr, feat_iss});
    assign wt_sr_nxt      = MEM_LAT'({wt_sr, wt_iss});
    assign bus.feat_valid = feat_sr[MEM_LAT-1];
    assign bus.wt_valid   = wt_sr[MEM_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            relu_q        <= 1'b0;
            pool_q        <= 1'b0;
            pass          <= '0;
            wt_base       <= '0;
            feat_iss      <= 1'b0;
            feat_sr       <= '0;
            wt_iss        <= 1'b0;
            wt_sr         <= '0;
            wt_cnt        <= '0;
            bus.feat_addr <= '0;
            bus.wt_addr   <= '0;
            bus.win_valid <= 1'b0;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
        end else begin
            done    <= 1'b0;
            feat_sr <= feat_sr_nxt;
            wt_sr   <= wt_sr_nxt;
            if (feat_iss) begin
                if (bus.feat_addr == ADDR_W'(N_IN - 1)) feat_iss <= 1'b0;
                else bus.feat_addr <= bus.feat_addr + 1'b1;
            end
            if (wt_iss) begin
                if (wt_cnt == ADDR_W'(WPF - 1)) begin
                    wt_iss <= 1'b0;
                end else begin
                    wt_cnt      <= wt_cnt + 1'b1;
                    bus.wt_addr <= bus.wt_addr + 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        relu_q        <= relu_en;
                        pool_q        <= pool_en;
                        pass          <= '0;
                        wt_base       <= '0;
                        bus.feat_addr <= '0;
                        feat_iss      <= 1'b1;
                        state         <= S_LOAD_INP;
                    end
                end
                S_LOAD_INP: begin
                    if (!feat_iss && feat_sr_nxt == '0) begin
                        bus.wt_addr <= wt_base;
                        wt_cnt      <= '0;
                        wt_iss      <= 1'b1;
                        state       <= S_LOAD_WT;
                    end
                end
                S_LOAD_WT: begin
                    if (!wt_iss && wt_sr_nxt == '0) begin
                        bus.win_valid <= 1'b1;
                        bus.win_row   <= '0;
                        bus.win_col   <= '0;
                        state         <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (bus.win_valid && bus.win_ready) begin
                        if (bus.win_row == ADDR_W'(OUT_H - 1) && bus.win_col == ADDR_W'(OUT_W - 1)) begin
                            bus.win_valid <= 1'b0;
                            state         <= S_DRAIN;
                        end else if (bus.win_col == ADDR_W'(OUT_W - 1)) begin
                            bus.win_col <= '0;
                            bus.win_row <= bus.win_row + 1'b1;
                        end else begin
                            bus.win_col <= bus.win_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // s1_valid low with every beat counted means the last write is on the bus now.
                    if (res_cnt == ADDR_W'(N_RES) && !s1_valid) begin
                        if (pass != ADDR_W'(PASSES - 1)) begin
                            pass        <= pass + 1'b1;
                            wt_base     <= wt_base + ADDR_W'(WPF);
                            bus.wt_addr <= wt_base + ADDR_W'(WPF);
                            wt_cnt      <= '0;
                            wt_iss      <= 1'b1;
                            state       <= S_LOAD_WT;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc = '0;
        for (int l = 0; l < FILT_PAR; l++) begin
            acc = '0;
            for (int ch = 0; ch < IN_CH; ch++)
                acc = acc + SW'(signed'(bus.mac_data[(l*IN_CH+ch)*DATA_WIDTH +: DATA_WIDTH]));
            if (acc > SAT_MAX)      lane_res[l] = DATA_WIDTH'(SAT_MAX);
            else if (acc < SAT_MIN) lane_res[l] = DATA_WIDTH'(SAT_MIN);
            else                    lane_res[l] = acc[DATA_WIDTH-1:0];
            if (relu_q && lane_res[l][DATA_WIDTH-1]) lane_res[l] = '0;
        end
    end

    assign res_take  = bus.mac_valid && (state == S_CONV || state == S_DRAIN) && (res_cnt < ADDR_W'(N_RES));
    assign pidx      = PB_IW'(s1_c >> 1);
    assign pool_drop = (W_ODD && s1_c == ADDR_W'(OUT_W - 1)) || (H_ODD && s1_r == ADDR_W'(OUT_H - 1));

    // Writes land in raster order and every pass writes the same count, so one running counter
    // yields pass*POH*POW + prow*POW + pcol without a multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt      <= '0;
            res_r        <= '0;
            res_c        <= '0;
            s1_valid     <= 1'b0;
            s1_r         <= '0;
            s1_c         <= '0;
            wr_cnt       <= '0;
            bus.out_we   <= 1'b0;
            bus.out_addr <= '0;
            bus.out_data <= '0;
            for (int l = 0; l < FILT_PAR; l++) begin
                s1_val[l] <= '0;
                ptmp[l]   <= '0;
                for (int i = 0; i < PB_N; i++) pbuf[l][i] <= '0;
            end
        end else begin
            bus.out_we <= 1'b0;
            s1_valid   <= res_take;
            if (state == S_IDLE) wr_cnt <= '0;
            if (state == S_LOAD_WT) begin
                res_cnt <= '0;
                res_r   <= '0;
                res_c   <= '0;
            end else if (res_take) begin
                res_cnt <= res_cnt + 1'b1;
                s1_r    <= res_r;
                s1_c    <= res_c;
                for (int l = 0; l < FILT_PAR; l++) s1_val[l] <= lane_res[l];
                if (res_c == ADDR_W'(OUT_W - 1)) begin
                    res_c <= '0;
                    res_r <= res_r + 1'b1;
                end else begin
                    res_c <= res_c + 1'b1;
                end
            end
            if (s1_valid) begin
                if (!pool_q) begin
                    bus.out_we   <= 1'b1;
                    bus.out_addr <= wr_cnt;
                    wr_cnt       <= wr_cnt + 1'b1;
                    for (int l = 0; l < FILT_PAR; l++)
                        bus.out_data[l*DATA_WIDTH +: DATA_WIDTH] <= s1_val[l];
                end else if (!pool_drop) begin
                    case ({s1_r[0], s1_c[0]})
                        2'b00: for (int l = 0; l < FILT_PAR; l++) ptmp[l] <= s1_val[l];
                        2'b01: for (int l = 0; l < FILT_PAR; l++) pbuf[l][pidx] <= smax(ptmp[l], s1_val[l]);
                        2'b10: for (int l = 0; l < FILT_PAR; l++) ptmp[l] <= smax(pbuf[l][pidx], s1_val[l]);
                        default: begin
                            bus.out_we   <= 1'b1;
                            bus.out_addr <= wr_cnt;
                            wr_cnt       <= wr_cnt + 1'b1;
                            for (int l = 0; l < FILT_PAR; l++)
                                bus.out_data[l*DATA_WIDTH +: DATA_WIDTH] <= smax(ptmp[l], s1_val[l]);
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_pool_layer_ctrl.sv
// tb/tb_conv_pool_layer_ctrl.sv - directed self-checking bench for conv_pool_layer_ctrl
module tb_conv_pool_layer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic relu_en = 1'b0, pool_en = 1'b0;
    logic busy0, done0, busy1, done1;

    always #5 clk = ~clk;

    conv_pool_layer_ctrl_if b0 ();
    conv_pool_layer_ctrl_if b1 ();

    conv_pool_layer_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start0), .relu_en(relu_en), .pool_en(pool_en),
        .busy(busy0), .done(done0), .bus(b0)
    );

    conv_pool_layer_ctrl #(.IN_W(8), .IN_H(8), .K(3), .NUM_FILT(4)) u_small (
        .clk(clk), .rst(rst), .start(start1), .relu_en(relu_en), .pool_en(pool_en),
        .busy(busy1), .done(done1), .bus(b1)
    );

    // One MAC model serves whichever instance sel picks.
    logic         sel = 1'b0;
    logic         wr = 1'b1, mv = 1'b0;
    logic [143:0] md = '0;
    int           mac_mode = 0;
    bit           bp_en = 1'b0;

    assign b0.win_ready = !sel && wr;
    assign b1.win_ready = sel && wr;
    assign b0.mac_valid = !sel && mv;
    assign b1.mac_valid = sel && mv;
    assign b0.mac_data  = md;
    assign b1.mac_data  = md;

    logic        m_win_valid, m_we, m_busy, m_done, m_fv, m_wv;
    logic [11:0] m_row, m_col, m_out_addr, m_fa, m_wa;
    logic [23:0] m_out_data;
    assign m_win_valid = sel ? b1.win_valid : b0.win_valid;
    assign m_row       = sel ? b1.win_row   : b0.win_row;
    assign m_col       = sel ? b1.win_col   : b0.win_col;
    assign m_we        = sel ? b1.out_we    : b0.out_we;
    assign m_out_addr  = sel ? b1.out_addr  : b0.out_addr;
    assign m_out_data  = sel ? b1.out_data  : b0.out_data;
    assign m_busy      = sel ? busy1 : busy0;
    assign m_done      = sel ? done1 : done0;
    assign m_fv        = sel ? b1.feat_valid : b0.feat_valid;
    assign m_wv        = sel ? b1.wt_valid   : b0.wt_valid;
    assign m_fa        = sel ? b1.feat_addr  : b0.feat_addr;
    assign m_wa        = sel ? b1.wt_addr    : b0.wt_addr;

    typedef struct { int unsigned addr; logic [23:0] data; } wr_t;
    typedef struct { int unsigned r; int unsigned c; } win_t;
    wr_t         wr_q[$];
    win_t        win_q[$];
    int unsigned fv_q[$];
    int unsigned wv_q[$];
    int          done_cnt, busy_at_done, busy_before_done, cyc, busy_rise_cyc, first_fv_cyc;
    logic        prev_busy = 1'b0;
    logic [11:0] fa_h1 = '0, fa_h2 = '0, wa_h1 = '0, wa_h2 = '0;

    int n_assert = 0;
    int n_fail   = 0;
    bit last_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        last_ok = 1'b1;
        assert (obs === exp) else begin
            n_fail++;
            last_ok = 1'b0;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_q.delete(); win_q.delete(); fv_q.delete(); wv_q.delete();
        done_cnt = 0; busy_at_done = -1; busy_before_done = -1;
        busy_rise_cyc = -1; first_fv_cyc = -1;
    endtask

    function automatic logic [143:0] mac_word(input int r, input int c);
        logic [143:0] w;
        logic [11:0]  v;
        w = '0;
        for (int l = 0; l < 2; l++)
            for (int ch = 0; ch < 6; ch++) begin
                case (mac_mode)
                    0:       v = 12'd1;
                    1:       v = (ch == 0) ? 12'(r * 10 + c) : 12'd0;
                    default: v = 12'h800;
                endcase
                w[(l*6+ch)*12 +: 12] = v;
            end
        return w;
    endfunction

    // MAC responder: window handshakes return results three cycles later, in order.
    bit dl_v[3];
    int dl_r[3], dl_c[3];
    initial begin
        forever begin
            @(negedge clk);
            mv = dl_v[2];
            md = mac_word(dl_r[2], dl_c[2]);
            for (int i = 2; i > 0; i--) begin
                dl_v[i] = dl_v[i-1]; dl_r[i] = dl_r[i-1]; dl_c[i] = dl_c[i-1];
            end
            wr = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            dl_v[0] = m_win_valid && wr;
            dl_r[0] = int'(m_row);
            dl_c[0] = int'(m_col);
            if (dl_v[0]) win_q.push_back('{r: m_row, c: m_col});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (m_we) wr_q.push_back('{addr: m_out_addr, data: m_out_data});
            if (m_done) begin
                done_cnt++;
                busy_at_done     = int'(m_busy);
                busy_before_done = int'(prev_busy);
            end
            if (m_busy && !prev_busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
            if (m_fv) begin
                fv_q.push_back(fa_h2);
                if (first_fv_cyc < 0) first_fv_cyc = cyc;
            end
            if (m_wv) wv_q.push_back(wa_h2);
            fa_h2 = fa_h1; fa_h1 = m_fa;
            wa_h2 = wa_h1; wa_h1 = m_wa;
            prev_busy = m_busy;
        end
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("run_completes", done_cnt > 0, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic run_layer(input bit s, input bit relu, input bit pool, input int mode, input bit bp);
        @(negedge clk); #1;
        sel = s; relu_en = relu; pool_en = pool; mac_mode = mode; bp_en = bp;
        clear_logs();
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        wait_done(20000);
    endtask

    task automatic check_writes(input string tag, input int n_exp, input logic [11:0] lane_exp);
        chk({tag, "_write_count"}, wr_q.size(), n_exp);
        for (int k = 0; k < wr_q.size(); k++) begin
            chk({tag, "_out_addr"}, wr_q[k].addr, k);
            if (!last_ok) break;
            chk({tag, "_lane0"}, wr_q[k].data[11:0], lane_exp);
            if (!last_ok) break;
            chk({tag, "_lane1"}, wr_q[k].data[23:12], lane_exp);
            if (!last_ok) break;
        end
    endtask

    task automatic check_windows(input string tag, input int passes, input int ow, input int oh);
        chk({tag, "_window_count"}, win_q.size(), passes * ow * oh);
        for (int k = 0; k < win_q.size(); k++) begin
            chk({tag, "_win_row"}, win_q[k].r, (k % (ow * oh)) / ow);
            if (!last_ok) break;
            chk({tag, "_win_col"}, win_q[k].c, k % ow);
            if (!last_ok) break;
        end
    endtask

    initial begin
        int n;
        clear_logs();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_out_we", b0.out_we, 0);
        chk("reset_feat_addr", b0.feat_addr, 0);
        chk("reset_win_valid", b0.win_valid, 0);
        chk("reset_out_data", b0.out_data, 0);
        rst = 1'b0;

        // Constant 1 per channel, ReLU + pool.
        run_layer(0, 1, 1, 0, 0);
        check_writes("const_pool", 200, 12'd6);
        check_windows("const_pool", 8, 10, 10);
        chk("const_done_count", done_cnt, 1);
        chk("busy_at_done", busy_at_done, 0);
        chk("busy_before_done", busy_before_done, 1);
        chk("feat_valid_count", fv_q.size(), 196);
        chk("feat_valid_lag", first_fv_cyc - busy_rise_cyc, 2);
        chk("feat_beat0_addr", fv_q.size() > 0 ? fv_q[0] : 32'hFFFF, 0);
        chk("feat_last_addr", fv_q.size() > 195 ? fv_q[195] : 32'hFFFF, 195);
        chk("wt_valid_count", wv_q.size(), 1208);
        chk("wt_pass3_first", wv_q.size() > 603 ? wv_q[453] : 32'hFFFF, 453);
        chk("wt_pass3_last", wv_q.size() > 603 ? wv_q[603] : 32'hFFFF, 603);
        chk("wt_pass7_last", wv_q.size() > 1207 ? wv_q[1207] : 32'hFFFF, 1207);

        // row*10+col in channel 0: pooled maxima.
        run_layer(0, 1, 1, 1, 0);
        chk("rc_write_count", wr_q.size(), 200);
        if (wr_q.size() == 200) begin
            chk("rc_pool_0_0", wr_q[0].data[11:0], 11);
            chk("rc_pool_1_2_lane0", wr_q[7].data[11:0], 35);
            chk("rc_pool_1_2_lane1", wr_q[7].data[23:12], 35);
            chk("rc_pool_4_4", wr_q[24].data[11:0], 99);
            chk("rc_pass5_1_2_addr", wr_q[132].addr, 132);
            chk("rc_pass5_1_2_data", wr_q[132].data[11:0], 35);
        end

        // Large negative sums saturate; ReLU clamps them.
        run_layer(0, 0, 1, 2, 0);
        check_writes("neg_sat", 200, 12'h800);
        run_layer(0, 1, 1, 2, 0);
        check_writes("neg_relu", 200, 12'd0);

        // Random backpressure on win_ready.
        run_layer(0, 1, 1, 0, 1);
        check_writes("bp", 200, 12'd6);
        check_windows("bp", 8, 10, 10);
        chk("bp_done_count", done_cnt, 1);

        // Reset in the middle of CONV aborts the run.
        @(negedge clk); #1;
        sel = 1'b0; bp_en = 1'b0; mac_mode = 0; relu_en = 1'b1; pool_en = 1'b1;
        clear_logs();
        start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        n = 0;
        while (!b0.win_valid && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reached_conv", b0.win_valid, 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_win_valid", b0.win_valid, 0);
        chk("abort_win_col", b0.win_col, 0);
        chk("abort_wt_addr", b0.wt_addr, 0);
        chk("abort_feat_addr", b0.feat_addr, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);

        // Clean run after the abort, with a second start while busy.
        clear_logs();
        start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        chk("busy_mid_run", busy0, 1);
        start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        wait_done(20000);
        check_writes("after_abort", 200, 12'd6);
        repeat (20) @(negedge clk);
        #1;
        chk("ignored_start_busy", busy0, 0);
        chk("ignored_start_done_count", done_cnt, 1);

        // K=3, 8x8 input, no pooling.
        run_layer(1, 1, 0, 0, 0);
        check_writes("small_nopool", 72, 12'd6);
        check_windows("small_nopool", 2, 6, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
